// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter for the display register.
// Ports: clk, rst (sync, high), start, bin_in -> busy, done, overflow, bcd_out.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10 ** DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   adj;
    logic [SCR_W-1:0]   nxt;
    logic [CNT_W-1:0]   cnt;

    // Digit-local add-3: each nibble wraps on its own, no carry between digits.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[BIN_W+4*i +: 4] >= 4'd5) begin
                adj[BIN_W+4*i +: 4] = scratch[BIN_W+4*i +: 4] + 4'd3;
            end
        end
        nxt = adj << 1;
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
            scratch  <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (bin_in > MAX_VAL) begin
                            // Not representable: flag it and show all ones.
                            bcd_out  <= '1;
                            overflow <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            scratch  <= {{BCD_W{1'b0}}, bin_in};
                            cnt      <= '0;
                            overflow <= 1'b0;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    scratch <= nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        bcd_out <= nxt[SCR_W-1 -: BCD_W];
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
// Drives and samples 1 time unit after each rising edge.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] bcd_out;

    int n_tests = 0;
    int n_fail  = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd_out  (bcd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int t;
        logic [15:0] r;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts edges after the accepting edge until done is visible.
    task automatic convert(input logic [13:0] v, input logic [15:0] exp_bcd,
                           input bit ovf, input bit poke);
        logic [15:0] prev;
        int lat;
        prev   = bcd_out;
        start  = 1'b1;
        bin_in = v;
        tick();
        start = 1'b0;
        lat   = 0;
        if (!ovf) begin
            check("ovf_clear_on_accept", overflow, 0);
            check("busy_after_accept", busy, 1);
        end
        while (!done && lat < 40) begin
            check("bcd_hold_shift", bcd_out, prev);
            check("busy_shift", busy, 1);
            if (poke && lat == 5) begin
                start  = 1'b1;
                bin_in = 14'd321;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("latency", lat, ovf ? 0 : 14);
        check("done", done, 1);
        check("bcd_out", bcd_out, exp_bcd);
        check("overflow", overflow, ovf);
        check("busy_at_done", busy, 0);
        tick();
        check("done_width", done, 0);
        check("bcd_hold_after", bcd_out, exp_bcd);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int lat;
        int cur;
        int nxt_v;
        int seen_done;

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_bcd", bcd_out, 16'h0000);

        convert(14'd0,    16'h0000, 1'b0, 1'b0);
        convert(14'd1234, 16'h1234, 1'b0, 1'b0);
        convert(14'd9999, 16'h9999, 1'b0, 1'b0);
        convert(14'd1000, 16'h1000, 1'b0, 1'b0);
        convert(14'd5,    16'h0005, 1'b0, 1'b0);
        convert(14'd10000, 16'hFFFF, 1'b1, 1'b0);
        convert(14'd16383, 16'hFFFF, 1'b1, 1'b0);
        convert(14'd42,   16'h0042, 1'b0, 1'b0);
        convert(14'd777,  16'h0777, 1'b0, 1'b1);
        convert(14'd5678, 16'h5678, 1'b0, 1'b0);

        // Reset in the middle of converting 4321.
        start  = 1'b1;
        bin_in = 14'd4321;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_bcd", bcd_out, 16'h0000);
        check("abort_done", done, 0);
        check("abort_ovf", overflow, 0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen_done++;
            tick();
        end
        check("abort_no_done", seen_done, 0);

        // Back-to-back with start held; bin_in steps through 0..9999.
        cur    = 0;
        bin_in = 14'd0;
        start  = 1'b1;
        tick();
        for (int k = 0; k <= 1429; k++) begin
            lat = 0;
            while (!done && lat < 40) begin
                tick();
                lat++;
            end
            check("sweep_lat", lat, 14);
            check("sweep_bcd", bcd_out, to_bcd(cur));
            if (k < 1429) begin
                nxt_v  = (k + 1 == 1429) ? 9999 : (k + 1) * 7;
                bin_in = 14'(nxt_v);
                cur    = nxt_v;
            end else begin
                start = 1'b0;
            end
            tick();
            check("sweep_done_width", done, 0);
            if (k < 1429) check("sweep_busy", busy, 1);
        end
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
